// File: rtl/cg_bank_ctrl.sv
// cg_bank_ctrl -- bank of glitch-free clock gates with per-channel idle shutdown.
//
// Each channel runs an OFF/ON/HOLD state machine. Activity (or the global
// ForceOn) opens the gate at once. Once activity stops, the gate stays open
// for IDLE_CYCLES more cycles and then closes. ForceOff holds a channel closed
// and wins over everything except TestEn. TestEn reaches only the TE pin of
// the gating cell, so scan mode never disturbs the state machines.
//
// Ports:
//   ClkIn    in   1    ungated source clock, all state on its rising edge
//   ResetB   in   1    asynchronous active-low reset
//   Active   in   NCH  per-channel activity request
//   ForceOn  in   1    hold every channel that is not forced off open
//   ForceOff in   NCH  per-channel hold-closed
//   TestEn   in   1    scan bypass, opens every gate through the cell TE pin
//   ClkOut   out  NCH  gated clocks
//   GateEn   out  NCH  registered enable per channel (cell E input)
//   AllIdle  out  1    registered, 1 when every GateEn bit is 0

module cg_bank_ctrl #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 4,
  parameter int IDLE_CYCLES = 8
) (
  input  logic           ClkIn,
  input  logic           ResetB,
  input  logic [NCH-1:0] Active,
  input  logic           ForceOn,
  input  logic [NCH-1:0] ForceOff,
  input  logic           TestEn,
  output logic [NCH-1:0] ClkOut,
  output logic [NCH-1:0] GateEn,
  output logic           AllIdle
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ON   = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Load value on entering HOLD. The count covers the cycles after the ON
  // cycle, so a run-out of N cycles loads N-1. This value is unused when
  // IDLE_CYCLES is 0.
  localparam logic [CNT_W-1:0] IDLE_LOAD =
      (IDLE_CYCLES == 0) ? {CNT_W{1'b0}} : CNT_W'(IDLE_CYCLES - 1);
  localparam logic IDLE_ZERO = (IDLE_CYCLES == 0);

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   en_q;
  logic [NCH-1:0]   en_d;
  logic [NCH-1:0]   wake_s;
  logic             all_idle_q;

  assign wake_s = Active | {NCH{ForceOn}};

  // Per-channel next state. The priority order is ForceOff, then
  // ForceOn/Active, then the idle run-out.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        ST_OFF: begin
          if (ForceOff[i]) begin
            state_d[i] = ST_OFF;
          end else if (wake_s[i]) begin
            state_d[i] = ST_ON;
          end else begin
            state_d[i] = ST_OFF;
          end
        end
        ST_ON: begin
          if (ForceOff[i]) begin
            state_d[i] = ST_OFF;
          end else if (wake_s[i]) begin
            state_d[i] = ST_ON;
          end else if (IDLE_ZERO) begin
            state_d[i] = ST_OFF;
          end else begin
            state_d[i] = ST_HOLD;
            cnt_d[i]   = IDLE_LOAD;
          end
        end
        ST_HOLD: begin
          if (ForceOff[i]) begin
            state_d[i] = ST_OFF;
          end else if (wake_s[i]) begin
            state_d[i] = ST_ON;
          end else if (cnt_q[i] == {CNT_W{1'b0}}) begin
            state_d[i] = ST_OFF;
          end else begin
            // Decrement only from a nonzero count, so the counter never wraps.
            cnt_d[i] = cnt_q[i] - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_d[i] = ST_OFF;
        end
      endcase
      // The gate is open in every state except OFF.
      en_d[i] = (state_d[i] != ST_OFF);
    end
  end

  // State, counter, enable and idle-flag registers. AllIdle is taken from the
  // next enable values so that it updates on the same edge as GateEn.
  always_ff @(posedge ClkIn or negedge ResetB) begin
    if (!ResetB) begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= ST_OFF;
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
      en_q       <= {NCH{1'b0}};
      all_idle_q <= 1'b1;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      en_q       <= en_d;
      all_idle_q <= ~(|en_d);
    end
  end

  assign GateEn  = en_q;
  assign AllIdle = all_idle_q;

  // One integrated clock-gating cell per channel. The clock path contains
  // only this cell.
  for (genvar g = 0; g < NCH; g++) begin : g_icg
    CKLNQD1 u_icg (
      .CP (ClkIn),
      .E  (en_q[g]),
      .TE (TestEn),
      .Q  (ClkOut[g])
    );
  end

endmodule

// CKLNQD1 -- behavioural model of a latch-based integrated clock gate.
// The latch is transparent while CP is low and holds while CP is high. A
// change on E or TE during the high phase, including an async reset of E,
// therefore cannot truncate or create a pulse.
// Ports: CP clock in, E enable, TE test enable, Q gated clock out.
module CKLNQD1 (
  input  logic CP,
  input  logic E,
  input  logic TE,
  output logic Q
);

  logic en_l;

  // Enable latch, transparent in the low phase of CP.
  always_latch begin
    if (!CP) begin
      en_l <= E | TE;
    end
  end

  assign Q = CP & en_l;

endmodule

// File: tb/tb_cg_bank_ctrl.sv
// Directed self-checking bench for cg_bank_ctrl. The main instance uses the
// default parameters. A second instance, with IDLE_CYCLES=0, shares the same
// inputs and is checked only in test_idle0.
module tb_cg_bank_ctrl;

  logic       clk = 1'b0;
  logic       resetb = 1'b0;
  logic [3:0] active = 4'hF;
  logic       force_on = 1'b0;
  logic [3:0] force_off = 4'h0;
  logic       test_en = 1'b0;
  logic [3:0] clk_out, gate_en, clk_out0, gate_en0;
  logic       all_idle, all_idle0;

  int n_vec = 0;
  int n_err = 0;
  int pc  [4];
  int pc0 [4];
  logic [3:0] prev  = 4'h0;
  logic [3:0] prev0 = 4'h0;

  always #5 clk = ~clk;

  cg_bank_ctrl #(.NCH(4), .CNT_W(4), .IDLE_CYCLES(8)) u_dut (
    .ClkIn(clk), .ResetB(resetb), .Active(active), .ForceOn(force_on),
    .ForceOff(force_off), .TestEn(test_en), .ClkOut(clk_out),
    .GateEn(gate_en), .AllIdle(all_idle)
  );

  cg_bank_ctrl #(.NCH(4), .CNT_W(4), .IDLE_CYCLES(0)) u_dut0 (
    .ClkIn(clk), .ResetB(resetb), .Active(active), .ForceOn(force_on),
    .ForceOff(force_off), .TestEn(test_en), .ClkOut(clk_out0),
    .GateEn(gate_en0), .AllIdle(all_idle0)
  );

  // Count rising edges on each gated clock.
  always @(clk_out) begin
    for (int i = 0; i < 4; i++) if (clk_out[i] && !prev[i]) pc[i]++;
    prev = clk_out;
  end

  always @(clk_out0) begin
    for (int i = 0; i < 4; i++) if (clk_out0[i] && !prev0[i]) pc0[i]++;
    prev0 = clk_out0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pc;
    for (int i = 0; i < 4; i++) begin
      pc[i] = 0;
      pc0[i] = 0;
    end
  endtask

  task automatic test_reset;
    clr_pc();
    repeat (3) tick();
    n_vec++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL rst_gate_en got %h exp %h", gate_en, 4'h0); end
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL rst_all_idle got %b exp %b", all_idle, 1'b1); end
    n_vec++; if (clk_out !== 4'h0) begin n_err++; $display("FAIL rst_clk_out got %h exp %h", clk_out, 4'h0); end
    n_vec++; if (pc[0] + pc[1] + pc[2] + pc[3] !== 0) begin n_err++; $display("FAIL rst_pulses got %0d exp 0", pc[0] + pc[1] + pc[2] + pc[3]); end
    resetb = 1'b1;
    clr_pc();
    tick();
    n_vec++; if (gate_en !== 4'hF) begin n_err++; $display("FAIL rel_gate_en got %h exp %h", gate_en, 4'hF); end
    n_vec++; if (all_idle !== 1'b0) begin n_err++; $display("FAIL rel_all_idle got %b exp %b", all_idle, 1'b0); end
    n_vec++; if (pc[0] !== 0) begin n_err++; $display("FAIL rel_no_pulse_edge1 got %0d exp 0", pc[0]); end
    tick();
    n_vec++; if (clk_out !== 4'hF) begin n_err++; $display("FAIL rel_clk_out_edge2 got %h exp %h", clk_out, 4'hF); end
    n_vec++; if (pc[0] !== 1) begin n_err++; $display("FAIL rel_pulse_edge2 got %0d exp 1", pc[0]); end
    active = 4'h0;
    repeat (12) tick();
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL rel_settle_idle got %b exp %b", all_idle, 1'b1); end
  endtask

  task automatic test_runout;
    active = 4'b0001;
    tick();
    active = 4'b0000;
    clr_pc();
    repeat (8) tick();
    n_vec++; if (gate_en[0] !== 1'b1) begin n_err++; $display("FAIL runout_en_edge8 got %b exp %b", gate_en[0], 1'b1); end
    n_vec++; if (all_idle !== 1'b0) begin n_err++; $display("FAIL runout_idle_edge8 got %b exp %b", all_idle, 1'b0); end
    tick();
    n_vec++; if (gate_en[0] !== 1'b0) begin n_err++; $display("FAIL runout_en_edge9 got %b exp %b", gate_en[0], 1'b0); end
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL runout_idle_edge9 got %b exp %b", all_idle, 1'b1); end
    repeat (3) tick();
    n_vec++; if (pc[0] !== 9) begin n_err++; $display("FAIL runout_pulses got %0d exp 9", pc[0]); end
  endtask

  task automatic test_retrigger;
    int gaps;
    gaps = 0;
    active = 4'b0010;
    tick();
    clr_pc();
    for (int e = 1; e <= 14; e++) begin
      active = (e == 5) ? 4'b0010 : 4'b0000;
      tick();
      if (e < 14 && gate_en[1] !== 1'b1) gaps++;
    end
    n_vec++; if (gaps !== 0) begin n_err++; $display("FAIL retrig_gaps got %0d exp 0", gaps); end
    n_vec++; if (gate_en[1] !== 1'b0) begin n_err++; $display("FAIL retrig_en_edge14 got %b exp %b", gate_en[1], 1'b0); end
    repeat (3) tick();
    n_vec++; if (pc[1] !== 14) begin n_err++; $display("FAIL retrig_pulses got %0d exp 14", pc[1]); end
  endtask

  task automatic test_priority;
    int bad;
    bad = 0;
    active = 4'hF; force_off = 4'b0101; force_on = 1'b1;
    tick();
    n_vec++; if (gate_en !== 4'b1010) begin n_err++; $display("FAIL prio_gate_en got %b exp %b", gate_en, 4'b1010); end
    n_vec++; if (all_idle !== 1'b0) begin n_err++; $display("FAIL prio_all_idle got %b exp %b", all_idle, 1'b0); end
    test_en = 1'b1;
    clr_pc();
    repeat (3) tick();
    for (int i = 0; i < 4; i++) if (pc[i] !== 3) bad++;
    n_vec++; if (bad !== 0) begin n_err++; $display("FAIL prio_testen_pulses got %0d/%0d/%0d/%0d exp 3 each", pc[0], pc[1], pc[2], pc[3]); end
    n_vec++; if (gate_en !== 4'b1010) begin n_err++; $display("FAIL prio_testen_gate_en got %b exp %b", gate_en, 4'b1010); end
    test_en = 1'b0;
    active = 4'h0; force_on = 1'b0; force_off = 4'h0;
    repeat (12) tick();
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL prio_settle_idle got %b exp %b", all_idle, 1'b1); end
  endtask

  task automatic test_force_off;
    active = 4'b1000;
    tick();
    force_off = 4'b1000;
    tick();
    n_vec++; if (gate_en[3] !== 1'b0) begin n_err++; $display("FAIL foff_gate_en got %b exp %b", gate_en[3], 1'b0); end
    clr_pc();
    repeat (2) tick();
    n_vec++; if (pc[3] !== 0) begin n_err++; $display("FAIL foff_pulses got %0d exp 0", pc[3]); end
    force_off = 4'h0; active = 4'h0;
    tick();
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL foff_all_idle got %b exp %b", all_idle, 1'b1); end
  endtask

  task automatic test_idle0;
    active = 4'b0100;
    tick();
    active = 4'b0000;
    clr_pc();
    tick();
    n_vec++; if (gate_en0[2] !== 1'b0) begin n_err++; $display("FAIL idle0_gate_en got %b exp %b", gate_en0[2], 1'b0); end
    n_vec++; if (all_idle0 !== 1'b1) begin n_err++; $display("FAIL idle0_all_idle got %b exp %b", all_idle0, 1'b1); end
    repeat (3) tick();
    n_vec++; if (pc0[2] !== 1) begin n_err++; $display("FAIL idle0_pulses got %0d exp 1", pc0[2]); end
    repeat (10) tick();
  endtask

  task automatic test_reset_mid_hold;
    active = 4'b0001;
    tick();
    active = 4'b0000;
    repeat (2) tick();
    resetb = 1'b0;
    #1;
    n_vec++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL midrst_gate_en got %h exp %h", gate_en, 4'h0); end
    n_vec++; if (all_idle !== 1'b1) begin n_err++; $display("FAIL midrst_all_idle got %b exp %b", all_idle, 1'b1); end
    n_vec++; if (clk_out[0] !== 1'b1) begin n_err++; $display("FAIL midrst_high_kept got %b exp %b", clk_out[0], 1'b1); end
    n_vec++; if (u_dut.cnt_q[0] !== 4'd0) begin n_err++; $display("FAIL midrst_cnt got %0d exp 0", u_dut.cnt_q[0]); end
    #2;
    n_vec++; if (clk_out[0] !== 1'b1) begin n_err++; $display("FAIL midrst_full_width got %b exp %b", clk_out[0], 1'b1); end
    @(negedge clk);
    #1;
    n_vec++; if (clk_out[0] !== 1'b0) begin n_err++; $display("FAIL midrst_low got %b exp %b", clk_out[0], 1'b0); end
    clr_pc();
    repeat (3) tick();
    resetb = 1'b1;
    repeat (2) tick();
    n_vec++; if (pc[0] !== 0) begin n_err++; $display("FAIL midrst_no_pulses got %0d exp 0", pc[0]); end
    n_vec++; if (gate_en !== 4'h0) begin n_err++; $display("FAIL midrst_state_off got %h exp %h", gate_en, 4'h0); end
  endtask

  initial begin
    clr_pc();
    test_reset();
    test_runout();
    test_retrigger();
    test_priority();
    test_force_off();
    test_idle0();
    test_reset_mid_hold();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
